cic_interp: RTL and testbench

Parametrised N-stage CIC interpolator for the interpolation filter chain. It replaces the single fixed comb stage with a complete cascade:
- N comb stages (differential delay M) at the input rate;
- a zero-stuffing upsampler by R;
- N integrator stages at the clock rate.

Input samples arrive through a valid/ready handshake, one per R clock cycles. Output is a full-precision sample stream with a per-cycle valid flag, feeding the downstream compensation/output stage.

---
 rtl/cic_interp.sv | 134 +++++++++++++
 tb/tb_cic_interp.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp.sv
`default_nettype none
// ============================================================================
// Module   : cic_interp
// Purpose  : N-stage CIC interpolator: combs at the input rate, zero-stuffing
//            by R, then integrators at the clock rate. Full-precision output.
// Revision : 1.0 - initial release
// ============================================================================
module cic_interp #(
   parameter int IN_W  = 16,
   parameter int N     = 3,
   parameter int R     = 8,
   parameter int M     = 1,
   // Derived width; leave at its default.
   parameter int ACC_W = IN_W + N * $clog2(R * M)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  d_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [ACC_W-1:0] d_out,
   output logic                    out_valid
);

   localparam int c_PH_W  = $clog2(R);
   localparam int c_CNT_W = $clog2(N + 1);
   localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(R - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(N);

   logic [c_PH_W-1:0]       ph_q, ph_d;
   logic [c_CNT_W-1:0]      cnt_q, cnt_d;
   logic                    primed_q, primed_d;
   logic                    out_valid_q, out_valid_d;
   logic                    w_adv;
   logic                    w_accept;
   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] w_comb  [0:N];
   logic signed [ACC_W-1:0] z_q     [1:N][0:M-1];
   logic signed [ACC_W-1:0] z_d     [1:N][0:M-1];
   // integ_*[0] is the upsampler register feeding the first integrator.
   logic signed [ACC_W-1:0] integ_q [0:N];
   logic signed [ACC_W-1:0] integ_d [0:N];

   assign w_ext = {{(ACC_W - IN_W){d_in[IN_W-1]}}, d_in};

   always_comb begin
      w_adv    = (ph_q != '0) | in_valid;
      w_accept = (ph_q == '0) & in_valid;
      ph_d     = ph_q;
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (w_adv) begin
         ph_d = (ph_q == c_PH_LAST) ? '0 : ph_q + c_PH_W'(1);
         // Counter saturates at N; the (N+1)th advance sets primed.
         if (!primed_q) begin
            if (cnt_q == c_CNT_FULL) begin
               primed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end
      end
      out_valid_d = w_adv & primed_d;
   end

   always_comb begin
      w_comb[0] = w_ext;
      for (int k = 1; k <= N; k++) begin
         w_comb[k] = w_comb[k-1] - z_q[k][M-1];
      end
   end

   always_comb begin
      for (int k = 1; k <= N; k++) begin
         for (int j = 0; j < M; j++) begin
            z_d[k][j] = z_q[k][j];
         end
      end
      for (int k = 0; k <= N; k++) begin
         integ_d[k] = integ_q[k];
      end
      if (w_accept) begin
         for (int k = 1; k <= N; k++) begin
            z_d[k][0] = w_comb[k-1];
            for (int j = 1; j < M; j++) begin
               z_d[k][j] = z_q[k][j-1];
            end
         end
      end
      if (w_adv) begin
         integ_d[0] = w_accept ? w_comb[N] : '0;
         // Wrap-around is intentional; the combs cancel the integrator growth.
         for (int k = 1; k <= N; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph_q        <= '0;
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < M; j++) begin
               z_q[k][j] <= '0;
            end
         end
         for (int k = 0; k <= N; k++) begin
            integ_q[k] <= '0;
         end
      end else begin
         ph_q        <= ph_d;
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < M; j++) begin
               z_q[k][j] <= z_d[k][j];
            end
         end
         for (int k = 0; k <= N; k++) begin
            integ_q[k] <= integ_d[k];
         end
      end
   end

   assign in_ready  = (ph_q == '0);
   assign d_out     = integ_q[N];
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_interp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_interp
// Purpose  : Scoreboard bench for cic_interp; expected stream from an FIR model
//            built from the convolved boxcar impulse response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_interp;

   localparam int IN_W  = 16;
   localparam int NB    = 3;
   localparam int RB    = 8;
   localparam int MB    = 1;
   localparam int ACC_W = 25;
   localparam int HLEN  = NB * (RB * MB - 1) + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic signed [IN_W-1:0]  d_in;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [ACC_W-1:0] d_out;
   logic                    out_valid;

   logic signed [15:0] a_d_in;
   logic               a_in_valid;
   logic               a_in_ready;
   logic signed [17:0] a_d_out;
   logic               a_out_valid;

   cic_interp dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d_out     (d_out),
      .out_valid (out_valid)
   );

   cic_interp #(.IN_W(16), .N(1), .R(4), .M(1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .d_in      (a_d_in),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .d_out     (a_d_out),
      .out_valid (a_out_valid)
   );

   int checks   = 0;
   int failures = 0;

   logic signed [ACC_W-1:0] exp_q [$];
   longint                  xs [$];
   longint                  h [HLEN];
   int                      tb_ph;
   int                      cyc;
   int                      first_acc;
   int                      first_val;
   int                      n_out;
   logic signed [ACC_W-1:0] last_out;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tb_ph <= 0;
         cyc   <= 0;
      end else begin
         cyc <= cyc + 1;
         if (tb_ph != 0 || in_valid)
            tb_ph <= (tb_ph == RB - 1) ? 0 : tb_ph + 1;
      end
   end

   task automatic build_h();
      longint t [HLEN];
      int len = 1;
      foreach (h[i]) h[i] = 0;
      h[0] = 1;
      for (int s = 0; s < NB; s++) begin
         foreach (t[i]) t[i] = 0;
         for (int i = 0; i < len; i++)
            for (int b = 0; b < RB * MB; b++)
               t[i+b] += h[i];
         len += RB * MB - 1;
         foreach (h[i]) h[i] = t[i];
      end
   endtask

   task automatic push_expected(input longint x);
      int j;
      longint acc;
      logic signed [ACC_W-1:0] e;
      xs.push_back(x);
      j = xs.size() - 1;
      for (int r = 0; r < RB; r++) begin
         acc = 0;
         for (int m = 0; m <= j; m++) begin
            int idx = (j - m) * RB + r;
            if (idx < HLEN) acc += xs[m] * h[idx];
         end
         e = acc[ACC_W-1:0];
         exp_q.push_back(e);
      end
   endtask

   task automatic monitor_outputs();
      logic signed [ACC_W-1:0] e;
      checks++;
      if (in_ready !== (tb_ph == 0)) begin
         failures++;
         $display("FAIL in_ready: got %b want %b (phase %0d)", in_ready, (tb_ph == 0), tb_ph);
      end
      if (out_valid === 1'b1) begin
         n_out++;
         last_out = d_out;
         if (first_val < 0) first_val = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got d_out=%0d want no output", d_out);
         end else begin
            e = exp_q.pop_front();
            if (d_out !== e) begin
               failures++;
               $display("FAIL d_out_stream: got %0d want %0d (output %0d)", d_out, e, n_out);
            end
         end
      end
   endtask

   // Sets inputs for the next edge, then samples that edge's outputs at negedge.
   task automatic drive(input bit v, input logic signed [IN_W-1:0] x);
      @(posedge clk);
      #1;
      in_valid = v;
      d_in     = x;
      if (v && tb_ph == 0) begin
         if (first_acc < 0) first_acc = cyc + 1;
         push_expected(longint'(x));
      end
      @(negedge clk);
      monitor_outputs();
   endtask

   task automatic send(input logic signed [IN_W-1:0] x, input bit noise);
      drive(1'b1, x);
      for (int r = 1; r < RB; r++) begin
         if (noise) drive($urandom_range(0, 1) == 1, IN_W'($urandom));
         else       drive(1'b0, '0);
      end
   endtask

   task automatic hold_reset();
      #1 rst = 1'b0;
      in_valid = 1'b0;
      d_in     = '0;
      repeat (3) @(posedge clk);
      exp_q.delete();
      xs.delete();
      n_out     = 0;
      first_acc = -1;
      first_val = -1;
      last_out  = '0;
      #2 rst = 1'b1;
   endtask

   task automatic check_run(input string name, input int samples, input longint steady);
      drive(1'b0, '0);
      checks++;
      if (first_val - first_acc !== NB) begin
         failures++;
         $display("FAIL %s_latency: got %0d edges want %0d", name, first_val - first_acc, NB);
      end
      checks++;
      if (last_out !== ACC_W'(steady)) begin
         failures++;
         $display("FAIL %s_steady: got %0d want %0d", name, last_out, steady);
      end
      checks++;
      if (n_out !== samples * RB - NB) begin
         failures++;
         $display("FAIL %s_count: got %0d outputs want %0d", name, n_out, samples * RB - NB);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || d_out !== '0 ||
             a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_d_out !== '0) begin
            failures++;
            $display("FAIL reset_values: got ready=%b valid=%b d_out=%0d want 1 0 0",
                     in_ready, out_valid, d_out);
         end
      end
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_impulse();
      logic signed [17:0] want;
      @(posedge clk);
      #1;
      a_in_valid = 1'b1;
      a_d_in     = 16'sd1;
      @(posedge clk);
      #1 a_d_in = '0;
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL impulse_prime: got valid=%b want 0", a_out_valid);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         want = (k <= 4) ? 18'sd1 : 18'sd0;
         checks++;
         if (a_out_valid !== 1'b1 || a_d_out !== want) begin
            failures++;
            $display("FAIL impulse_out: got valid=%b d_out=%0d want 1 %0d (k=%0d)",
                     a_out_valid, a_d_out, want, k);
         end
      end
      a_in_valid = 1'b0;
   endtask

   task automatic test_dc();
      hold_reset();
      for (int s = 0; s < 6; s++) send(16'sd100, 1'b0);
      check_run("dc", 6, 6400);
   endtask

   task automatic test_fullscale();
      hold_reset();
      for (int s = 0; s < 6; s++) send(-16'sd32768, 1'b0);
      check_run("fullscale", 6, -2097152);
   endtask

   task automatic test_stall();
      int  zeros = 0;
      logic signed [IN_W-1:0] x;
      hold_reset();
      for (int s = 0; s < 4; s++) send(IN_W'($urandom), 1'b1);
      drive(1'b0, '0);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_before: got valid=%b want 1", out_valid);
      end
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, IN_W'($urandom));
         if (out_valid === 1'b0) zeros++;
      end
      x = IN_W'($urandom);
      drive(1'b1, x);
      if (out_valid === 1'b0) zeros++;
      drive(1'b0, '0);
      checks++;
      if (zeros !== 5 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_gap: got %0d invalid cycles, resume valid=%b want 5 1", zeros, out_valid);
      end
      for (int r = 2; r < RB; r++) drive($urandom_range(0, 1) == 1, IN_W'($urandom));
      for (int s = 0; s < 3; s++) send(IN_W'($urandom), 1'b1);
      drive(1'b0, '0);
      checks++;
      if (n_out !== 8 * RB - NB) begin
         failures++;
         $display("FAIL stall_count: got %0d outputs want %0d", n_out, 8 * RB - NB);
      end
   endtask

   task automatic test_reset_mid();
      hold_reset();
      for (int s = 0; s < 4; s++) send(16'sd100, 1'b0);
      drive(1'b0, '0);
      checks++;
      if (out_valid !== 1'b1 || d_out !== 25'sd6400) begin
         failures++;
         $display("FAIL midreset_pre: got valid=%b d_out=%0d want 1 6400", out_valid, d_out);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || d_out !== '0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_clear: got valid=%b d_out=%0d ready=%b want 0 0 1",
                  out_valid, d_out, in_ready);
      end
      hold_reset();
      for (int s = 0; s < 5; s++) send(16'sd100, 1'b0);
      check_run("restart", 5, 6400);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      d_in       = '0;
      a_in_valid = 1'b0;
      a_d_in     = '0;
      first_acc  = -1;
      first_val  = -1;
      n_out      = 0;
      last_out   = '0;
      build_h();
      #1;
      test_reset();
      test_impulse();
      test_dc();
      test_fullscale();
      test_stall();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
